fpu_issue_ctrl: RTL
===================

# fpu_issue_ctrl

Single-issue FPU scheduler between the CPU execute stage and the FPU arithmetic units (adder, multiplier, `fless` comparator, divider). It accepts one FP operation per cycle over a valid/ready handshake and drives the start strobe and operands of the selected unit. It tracks every in-flight operation by its fixed latency and returns results in order of completion on a single write-back port. It refuses any issue that would collide with an already reserved write-back cycle.

## Interface
Parameters:
- `ADD_LAT`, 2: fadd/fsub latency in cycles (pipelined unit).
- `MUL_LAT`, 2: fmul latency (pipelined unit).
- `CMP_LAT`, 1: fless latency (registered unit).
- `DIV_LAT`, 8: fdiv latency (non-pipelined unit).

Ports:
- `clk`  in  1: the single clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `flush`  in  1: synchronous; discards all in-flight write-backs.
- `req_valid`  in  1: operation offered.
- `req_ready`  out  1: operation accepted this cycle when high together with `req_valid`.
- `req_op`  in  3: opcode from `fpu_pkg::fop_t`.
- `req_rd`  in  5: destination register tag.
- `req_x1`, `req_x2`  in  32 each: IEEE-754 single-precision operands.
- `unit_a`, `unit_b`  out  32 each: operands broadcast to all units.
- `add_start`, `mul_start`, `cmp_start`, `div_start`  out  1 each: one-cycle start strobes.
- `add_y`, `mul_y`, `div_y`  in  32 each: unit results.
- `cmp_y`  in  1: fless result.
- `wb_valid`  out  1: write-back strobe.
- `wb_rd`  out  5: write-back tag.
- `wb_data`  out  32: write-back data.
- `err_op`  out  1: one-cycle pulse on an accepted illegal opcode.

## Operation
- Opcodes: FADD=0, FSUB=1, FMUL=2, FLESS=3, FDIV=4; codes 5–7 are illegal.
- Acceptance at cycle t is `req_valid & req_ready`. The requester holds `req_*` stable while valid and not ready.
- On acceptance the matching `*_start` is high in cycle t.
  - `unit_a` = `req_x1`.
  - `unit_b` = `req_x2`, except FSUB, where `unit_b` = {~x2[31], x2[30:0]} on the adder.
- Latency L per op comes from the parameters. The unit result is sampled at the end of cycle t+L.
- `wb_valid` is high for exactly cycle t+L+1, with `wb_rd` and `wb_data` registered. FLESS gives `wb_data` = {31'b0, cmp_y}.
- Write-back reservation uses a shift register of depth max(L)+1. Each slot holds {valid, rd, unit sel}.
- `req_ready` is 0 when any of the following holds:
  - the target write-back cycle t+L+1 is already reserved;
  - the op is FDIV and the divider is busy;
  - `flush` is high.
- Divider busy: a counter is loaded with `DIV_LAT` on `div_start` and decremented to 0. A new FDIV may issue in the cycle the counter reads 0.
- Illegal op: `req_ready` = 1, accepted, no start strobe, no write-back, `err_op` high in cycle t+1.
- Flush clears all reservation slots, so no `wb_valid` occurs for ops issued before the flush.
  - The divider counter is not cleared by flush, because the unit is still running.
  - A result landing in the flush cycle is dropped.
- Simultaneous flush and request: flush wins and nothing is accepted.

## Timing
- Reset values: `req_ready`=0 during reset; all `*_start`=0, `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `err_op`=0; slots empty; div counter 0.
- `req_ready` is combinational from `req_op`, the slot state and `flush`. Start strobes and unit operands are combinational from the request.
- Throughput: one op per cycle when write-back slots do not collide.
  - Example: FLESS issued at t+1 after FADD at t, with L=1 and L=2, both targets t+3. The FLESS stalls one cycle.
- Reset asserted mid-operation: all state clears immediately. No write-back appears after reset release for ops issued before it.

## Configuration
- `FPU_DIV_EN` defined:
  - FDIV is dispatched to the divider with `DIV_LAT` and the busy interlock.
- `FPU_DIV_EN` undefined:
  - `div_start` is tied 0 and `div_y` is ignored.
  - FDIV is accepted with L=1 (no busy interlock) and writes back 32'h7FC00000 (quiet NaN).

## Structure
- `fpu_pkg` holds:
  - `fop_t` enum;
  - the canonical NaN constant;
  - the slot struct {valid, rd[4:0], sel};
  - the unit-select enum.
- One sub-module, `fpu_wb_resv`: the reservation shift register with reserve/query/flush ports and the aligned output slot.
- `fpu_issue_ctrl` contains the decode, start logic, divider counter and write-back mux.

## Test plan
- FADD x1=3F800000, x2=40000000, rd=3 at t; adder model returns 40400000 → `wb_valid` in t+3, `wb_rd`=3, `wb_data`=40400000.
- FSUB x2=40000000 → `unit_b`=C0000000 in the issue cycle, `add_start`=1.
- FADD at t, then FLESS with `cmp_y`=1 and rd=7 offered at t+1 → `req_ready`=0 at t+1, accepted t+2, write-backs in t+3 (FADD) and t+4 (rd 7, data 1).
- Two back-to-back FDIV with `FPU_DIV_EN` → second waits 8 cycles after the first start. Without the macro, both are accepted and return 7FC00000 one cycle apart.
- FMUL issued, flush in t+1 → no `wb_valid` through t+5. A request offered with flush at t+1 is not accepted.
- req_op=6 → accepted, `err_op` pulse in t+1, no start strobe, no write-back. `rstn` low mid-FDIV → all outputs 0, no write-back after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU issue controller.
//   fop_t      - FP opcode encoding presented on req_op
//   usel_t     - which arithmetic unit feeds a write-back slot
//   wb_slot_t  - one write-back reservation {valid, rd, sel}
//   CANON_NAN  - quiet NaN returned by FDIV when the divider is not built
//   max_int    - elaboration-time helper for sizing the reservation line
package fpu_pkg;

    typedef enum logic [2:0] {
        FADD  = 3'd0,
        FSUB  = 3'd1,
        FMUL  = 3'd2,
        FLESS = 3'd3,
        FDIV  = 3'd4
    } fop_t;

    typedef enum logic [1:0] {
        SEL_ADD = 2'd0,
        SEL_MUL = 2'd1,
        SEL_CMP = 2'd2,
        SEL_DIV = 2'd3
    } usel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        usel_t      sel;
    } wb_slot_t;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fpu_wb_resv.sv
// fpu_wb_resv: write-back reservation shift register.
// Slot k holds the operation whose result is captured at the end of the
// cycle k cycles from now; slot 0 is the one being captured this cycle.
// Ports:
//   clk, rstn    - clock, asynchronous active-low reset
//   flush        - empties every slot (including the one landing now)
//   lat          - latency of the offered op; used for query and reserve
//   query_busy   - the write-back cycle that lat would target is taken
//   resv_en      - reserve the target slot for resv_slot
//   resv_slot    - content of the new reservation
//   head         - slot 0, aligned with the unit result to capture
module fpu_wb_resv
    import fpu_pkg::*;
#(
    parameter  int DEPTH = 3,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic [LW-1:0] lat,
    output logic          query_busy,
    input  logic          resv_en,
    input  wb_slot_t      resv_slot,
    output wb_slot_t      head
);

    localparam wb_slot_t EMPTY = '0;

    wb_slot_t [DEPTH-1:0] slot_reg;
    wb_slot_t [DEPTH-1:0] slot_next;
    logic     [DEPTH-1:0] hit;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        wb_slot_t shifted;
        if (gi < DEPTH - 1) begin : g_shift
            assign shifted = slot_reg[gi+1];
        end else begin : g_top
            assign shifted = EMPTY;
        end
        // An op with latency L that issues now lands in slot L-1 after the
        // shift, which is exactly where slot L moves to; querying slot L
        // therefore checks the same write-back cycle.
        assign slot_next[gi] = flush ? EMPTY
                             : (resv_en && (lat == LW'(gi + 1))) ? resv_slot
                             : shifted;
        assign hit[gi] = slot_reg[gi].valid && (lat == LW'(gi));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= slot_next;
        end
    end

    assign query_busy = |hit;
    assign head       = slot_reg[0];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-issue FPU scheduler.
// Accepts one FP op per cycle (valid/ready), strobes the selected unit,
// reserves the fixed-latency write-back cycle and returns results in
// completion order on one registered write-back port.
// Optional feature macro: FPU_DIV_EN
//   defined   - FDIV goes to the divider with DIV_LAT and a busy interlock
//   undefined - div_start tied 0, div_y ignored, FDIV returns quiet NaN
//               one cycle after issue (latency 1)
// Ports:
//   clk, rstn, flush                   - clock, async active-low reset, flush
//   req_valid/req_ready/req_op/req_rd  - issue handshake, opcode, dest tag
//   req_x1, req_x2                     - operands
//   unit_a, unit_b                     - operands broadcast to the units
//   add/mul/cmp/div_start              - one-cycle unit start strobes
//   add_y, mul_y, div_y, cmp_y         - unit results
//   wb_valid, wb_rd, wb_data           - write-back port
//   err_op                             - pulse after an illegal opcode
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 2,
    parameter int CMP_LAT = 1,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_x1,
    input  logic [31:0] req_x2,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        add_start,
    output logic        mul_start,
    output logic        cmp_start,
    output logic        div_start,
    input  logic [31:0] add_y,
    input  logic [31:0] mul_y,
    input  logic [31:0] div_y,
    input  logic        cmp_y,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_op
);

`ifdef FPU_DIV_EN
    localparam int DIV_EFF = DIV_LAT;
`else
    localparam int DIV_EFF = 1;
`endif
    localparam int MAX_LAT = max_int(max_int(ADD_LAT, MUL_LAT), max_int(CMP_LAT, DIV_EFF));
    localparam int DEPTH   = MAX_LAT + 1;
    localparam int LW      = $clog2(DEPTH + 1);

    logic          op_legal;
    logic          is_sub;
    logic          is_div;
    logic [LW-1:0] lat;
    usel_t         sel;
    logic          resv_busy;
    logic          div_busy;
    logic          accept;
    logic          issue;
    wb_slot_t      new_slot;
    wb_slot_t      head;
    logic [31:0]   div_data;
    logic [31:0]   wb_data_next;
    logic          capture;

    logic          wb_valid_reg;
    logic [4:0]    wb_rd_reg;
    logic [31:0]   wb_data_reg;
    logic          err_reg;

    // Opcode decode: latency and result source per op.
    always_comb begin
        op_legal = 1'b1;
        is_sub   = 1'b0;
        is_div   = 1'b0;
        lat      = '0;
        sel      = SEL_ADD;
        case (fop_t'(req_op))
            FADD:  lat = LW'(ADD_LAT);
            FSUB:  begin lat = LW'(ADD_LAT); is_sub = 1'b1; end
            FMUL:  begin lat = LW'(MUL_LAT); sel = SEL_MUL; end
            FLESS: begin lat = LW'(CMP_LAT); sel = SEL_CMP; end
            FDIV:  begin lat = LW'(DIV_EFF); sel = SEL_DIV; is_div = 1'b1; end
            default: op_legal = 1'b0;
        endcase
    end

    // Illegal ops never reserve a slot, so the slot check only gates legal ops.
    assign req_ready = rstn & ~flush & ~(op_legal & resv_busy) & ~(is_div & div_busy);
    assign accept    = req_valid & req_ready;
    assign issue     = accept & op_legal;

    assign unit_a    = req_x1;
    assign unit_b    = is_sub ? {~req_x2[31], req_x2[30:0]} : req_x2;
    assign add_start = issue & (sel == SEL_ADD);
    assign mul_start = issue & (sel == SEL_MUL);
    assign cmp_start = issue & (sel == SEL_CMP);

    assign new_slot = '{valid: 1'b1, rd: req_rd, sel: sel};

    fpu_wb_resv #(
        .DEPTH (DEPTH)
    ) u_resv (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .lat        (lat),
        .query_busy (resv_busy),
        .resv_en    (issue),
        .resv_slot  (new_slot),
        .head       (head)
    );

`ifdef FPU_DIV_EN
    localparam int CW = $clog2(DIV_LAT + 1);
    logic [CW-1:0] div_cnt_reg;
    logic [CW-1:0] div_cnt_next;

    assign div_start = issue & is_div;
    assign div_busy  = (div_cnt_reg != '0);
    assign div_data  = div_y;

    // Flush leaves the counter alone: the divider keeps running regardless.
    always_comb begin
        div_cnt_next = div_cnt_reg;
        if (div_start) begin
            div_cnt_next = CW'(DIV_LAT);
        end else if (div_busy) begin
            div_cnt_next = div_cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end
`else
    logic [31:0] unused_div;
    assign unused_div = div_y ^ 32'(DIV_LAT);
    assign div_start  = 1'b0;
    assign div_busy   = 1'b0;
    assign div_data   = CANON_NAN;
`endif

    always_comb begin
        wb_data_next = add_y;
        case (head.sel)
            SEL_ADD: wb_data_next = add_y;
            SEL_MUL: wb_data_next = mul_y;
            SEL_CMP: wb_data_next = {31'b0, cmp_y};
            SEL_DIV: wb_data_next = div_data;
            default: wb_data_next = add_y;
        endcase
    end

    // A result landing in the flush cycle is dropped.
    assign capture = head.valid & ~flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
            err_reg      <= 1'b0;
        end else begin
            wb_valid_reg <= capture;
            err_reg      <= accept & ~op_legal;
            if (capture) begin
                wb_rd_reg   <= head.rd;
                wb_data_reg <= wb_data_next;
            end
        end
    end

    assign wb_valid = wb_valid_reg;
    assign wb_rd    = wb_rd_reg;
    assign wb_data  = wb_data_reg;
    assign err_op   = err_reg;

endmodule
